// File: rtl/systolic_seq_ctrl_if.sv
// Handshake and PE-side bundle for the systolic sequencer.
// The scheduler/buffer side connects through the master modport and the
// sequencer through the slave modport.
// Optional macro STALL_CNT_EN adds the 16-bit stall_cnt observation output.
interface systolic_seq_ctrl_if #(
    parameter int WIDTH   = 8,
    parameter int ROW     = 3,
    parameter int MAX_VEC = 256
);
    localparam int CNT_W = $clog2(MAX_VEC + 1);

    logic                   start;
    logic [CNT_W-1:0]       num_vec;
    logic                   busy;
    logic                   done;
    logic                   w_valid;
    logic [WIDTH-1:0]       w_data;
    logic                   w_ready;
    logic                   f_valid;
    logic [WIDTH*ROW-1:0]   f_data;
    logic                   f_ready;
    logic                   pe_ctrl;
    logic [WIDTH-1:0]       pe_weight;
    logic [WIDTH*ROW-1:0]   pe_feature;
`ifdef STALL_CNT_EN
    logic [15:0]            stall_cnt;
`endif

    modport master (
        output start, num_vec, w_valid, w_data, f_valid, f_data,
`ifdef STALL_CNT_EN
        input  stall_cnt,
`endif
        input  busy, done, w_ready, f_ready, pe_ctrl, pe_weight, pe_feature
    );

    modport slave (
        input  start, num_vec, w_valid, w_data, f_valid, f_data,
`ifdef STALL_CNT_EN
        output stall_cnt,
`endif
        output busy, done, w_ready, f_ready, pe_ctrl, pe_weight, pe_feature
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one systolic weight-chain vector of ROW PEs.
// A job shifts ROW weights into the PE chain, streams num_vec feature vectors
// with lane i delayed by i cycles, drains the skew with zeros and pulses done.
// Optional macro STALL_CNT_EN adds a saturating stall-cycle counter output.
module systolic_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int ROW     = 3,
    parameter int MAX_VEC = 256
) (
    input  logic               clk,
    input  logic               rst,
    systolic_seq_ctrl_if.slave io_bus
);
    localparam int CNT_W  = $clog2(MAX_VEC + 1);
    localparam int WCNT_W = $clog2(ROW + 1);
    localparam logic [WCNT_W-1:0] ROW_LAST  = WCNT_W'(ROW - 1);
    localparam logic [CNT_W-1:0]  MAX_VEC_C = CNT_W'(MAX_VEC);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [WCNT_W-1:0]   r_phaseCnt;
    logic [CNT_W-1:0]    r_vecCnt;
    logic [CNT_W-1:0]    r_numVec;
    logic [CNT_W-1:0]    w_numVecClamped;
    logic                w_startAccept;
    logic                w_wBeat;
    logic                w_fBeat;
    logic                w_phaseLast;
    logic                w_vecLast;
    logic                w_busy;
    logic                w_done;
    logic                w_wReady;
    logic                w_fReady;
    logic                r_peCtrl;
    logic [WIDTH-1:0]    r_peWeight;

    assign w_startAccept   = (r_state == IDLE) && io_bus.start;
    assign w_wBeat         = (r_state == LOAD) && io_bus.w_valid;
    assign w_fBeat         = (r_state == STREAM) && io_bus.f_valid;
    assign w_numVecClamped = (io_bus.num_vec > MAX_VEC_C) ? MAX_VEC_C : io_bus.num_vec;
    assign w_phaseLast     = (r_phaseCnt == ROW_LAST);
    assign w_vecLast       = (r_vecCnt == (r_numVec - CNT_W'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and state-decoded outputs; readies depend on state only
    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_wReady    = 1'b0;
        w_fReady    = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (io_bus.start) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                w_wReady = 1'b1;
                if (io_bus.w_valid && w_phaseLast) begin
                    w_nextState = (r_numVec == '0) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                w_fReady = 1'b1;
                if (io_bus.f_valid && w_vecLast) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_phaseLast) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Shared phase counter: weight beats in LOAD, elapsed cycles in DRAIN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phaseCnt <= '0;
        end else if (r_state != w_nextState) begin
            r_phaseCnt <= '0;
        end else if (w_wBeat || (r_state == DRAIN)) begin
            r_phaseCnt <= r_phaseCnt + WCNT_W'(1);
        end
    end

    // Feature beat counter, only live while streaming
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vecCnt <= '0;
        end else if (r_state != STREAM) begin
            r_vecCnt <= '0;
        end else if (w_fBeat) begin
            r_vecCnt <= r_vecCnt + CNT_W'(1);
        end
    end

    // Job length is captured once at start, already clamped to MAX_VEC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_numVec <= '0;
        end else if (w_startAccept) begin
            r_numVec <= w_numVecClamped;
        end
    end

    // Weight shift: each accepted beat appears on the chain one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_peCtrl   <= 1'b0;
            r_peWeight <= '0;
        end else begin
            r_peCtrl <= w_wBeat;
            if (w_wBeat) begin
                r_peWeight <= io_bus.w_data;
            end
        end
    end

    for (genvar i = 0; i < ROW; i++) begin : g_lane
        logic [WIDTH-1:0] r_pipe [i+1];

        // Lane skew line: zeros enter on every non-beat cycle so bubbles and drain are clean
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s <= i; s++) begin
                    r_pipe[s] <= '0;
                end
            end else begin
                r_pipe[0] <= w_fBeat ? io_bus.f_data[i*WIDTH +: WIDTH] : '0;
                for (int s = 1; s <= i; s++) begin
                    r_pipe[s] <= r_pipe[s-1];
                end
            end
        end

        assign io_bus.pe_feature[i*WIDTH +: WIDTH] = r_pipe[i];
    end

`ifdef STALL_CNT_EN
    logic [15:0] r_stallCnt;
    logic        w_stallCycle;

    assign w_stallCycle = ((r_state == LOAD) && !io_bus.w_valid) ||
                          ((r_state == STREAM) && !io_bus.f_valid);

    // Stall counter restarts with each accepted job, saturates, and freezes while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (w_startAccept) begin
            r_stallCnt <= '0;
        end else if (w_stallCycle && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign io_bus.stall_cnt = r_stallCnt;
`endif

    assign io_bus.busy      = w_busy;
    assign io_bus.done      = w_done;
    assign io_bus.w_ready   = w_wReady;
    assign io_bus.f_ready   = w_fReady;
    assign io_bus.pe_ctrl   = r_peCtrl;
    assign io_bus.pe_weight = r_peWeight;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Testbench for systolic_seq_ctrl.
// Each job is planned as weight/feature beats separated by stall gaps; the
// expected PE-side timeline is derived from that plan and scoreboarded, while
// a negedge monitor compares the DUT against it every cycle.
// Honours STALL_CNT_EN when the design is built with it.
module tb_systolic_seq_ctrl;
    localparam int WIDTH   = 8;
    localparam int ROW     = 3;
    localparam int MAX_VEC = 256;
    localparam int CNT_W   = $clog2(MAX_VEC + 1);
    localparam int FW      = WIDTH * ROW;
    localparam int MAXLEN  = 1024;

    typedef struct { int cyc; logic [WIDTH-1:0] val; } wEvent_t;
    typedef struct { int cyc; int stalls; } dEvent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatched = 0;
    bit   checkEn = 1'b0;

    wEvent_t          weightQ[$];
    dEvent_t          doneQ[$];
    bit               expBusy[int];
    bit               expWReady[int];
    bit               expFReady[int];
    logic [FW-1:0]    expFeat[int];

    int               wGap[ROW];
    logic [WIDTH-1:0] wData[ROW];
    int               fGap[$];
    logic [FW-1:0]    fData[$];

    bit               wvA[MAXLEN];
    logic [WIDTH-1:0] wdA[MAXLEN];
    bit               fvA[MAXLEN];
    logic [FW-1:0]    fdA[MAXLEN];

    systolic_seq_ctrl_if #(.WIDTH(WIDTH), .ROW(ROW), .MAX_VEC(MAX_VEC)) io ();

    systolic_seq_ctrl #(.WIDTH(WIDTH), .ROW(ROW), .MAX_VEC(MAX_VEC)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (io)
    );

    always #5 clk = ~clk;

    // Cycle index shared by stimulus and monitor
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drop every expectation that lies after cycle r (used when a job is aborted by reset)
    task automatic purgeAfter(input int r);
        int keys[$];
        keys = {};
        foreach (expBusy[k]) if (k > r) keys.push_back(k);
        foreach (keys[n]) expBusy.delete(keys[n]);
        keys = {};
        foreach (expWReady[k]) if (k > r) keys.push_back(k);
        foreach (keys[n]) expWReady.delete(keys[n]);
        keys = {};
        foreach (expFReady[k]) if (k > r) keys.push_back(k);
        foreach (keys[n]) expFReady.delete(keys[n]);
        keys = {};
        foreach (expFeat[k]) if (k > r) keys.push_back(k);
        foreach (keys[n]) expFeat.delete(keys[n]);
        for (int n = weightQ.size() - 1; n >= 0; n--) if (weightQ[n].cyc > r) weightQ.delete(n);
        for (int n = doneQ.size() - 1; n >= 0; n--) if (doneQ[n].cyc > r) doneQ.delete(n);
    endtask

    task automatic addFeat(input int c, input int lane, input logic [WIDTH-1:0] v);
        logic [FW-1:0] tmp;
        tmp = expFeat.exists(c) ? expFeat[c] : '0;
        tmp[lane*WIDTH +: WIDTH] = v;
        expFeat[c] = tmp;
    endtask

    task automatic planRandom(input int nv, input int maxGap);
        int nvEff;
        logic [FW-1:0] v;
        nvEff = (nv > MAX_VEC) ? MAX_VEC : nv;
        for (int j = 0; j < ROW; j++) begin
            wGap[j]  = $urandom_range(0, maxGap);
            wData[j] = WIDTH'($urandom);
        end
        fGap.delete();
        fData.delete();
        for (int k = 0; k < nvEff; k++) begin
            for (int i = 0; i < ROW; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
            fGap.push_back($urandom_range(0, maxGap));
            fData.push_back(v);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            io.start   = 1'b0;
            io.num_vec = CNT_W'($urandom);
            io.w_valid = 1'($urandom);
            io.w_data  = WIDTH'($urandom);
            io.f_valid = 1'($urandom);
            io.f_data  = FW'({$urandom, $urandom});
            @(posedge clk);
            #1;
        end
    endtask

    // Plan one job from wGap/wData/fGap/fData, push its expected timeline, then drive it.
    // abortOff >= 0 asserts reset at that offset from the start cycle and ends the job there.
    task automatic applyStimulus(input int nv, input bit holdStart, input int abortOff);
        int nvEff, s, o, lastW, streamStart, lastF, doneOff, stalls;
        nvEff  = (nv > MAX_VEC) ? MAX_VEC : nv;
        s      = cyc;
        stalls = 0;
        o      = 1;
        for (int j = 0; j < ROW; j++) begin
            for (int g = 0; g < wGap[j]; g++) begin
                wvA[o] = 1'b0; wdA[o] = WIDTH'($urandom); o++; stalls++;
            end
            wvA[o] = 1'b1; wdA[o] = wData[j];
            weightQ.push_back('{s + o + 1, wData[j]});
            o++;
        end
        lastW       = o - 1;
        streamStart = o;
        for (int k = 0; k < nvEff; k++) begin
            for (int g = 0; g < fGap[k]; g++) begin
                fvA[o] = 1'b0; fdA[o] = FW'({$urandom, $urandom}); o++; stalls++;
            end
            fvA[o] = 1'b1; fdA[o] = fData[k];
            for (int i = 0; i < ROW; i++) addFeat(s + o + 1 + i, i, fData[k][i*WIDTH +: WIDTH]);
            o++;
        end
        lastF   = o - 1;
        doneOff = (nvEff == 0) ? streamStart + ROW : lastF + ROW + 1;
        for (int t = 1; t <= doneOff; t++) expBusy[s + t] = 1'b1;
        for (int t = 1; t <= lastW; t++) expWReady[s + t] = 1'b1;
        for (int t = streamStart; t <= lastF; t++) expFReady[s + t] = 1'b1;
        doneQ.push_back('{s + doneOff, stalls});

        for (o = 0; o <= doneOff; o++) begin
            if (o == abortOff) begin
                rst = 1'b1;
                purgeAfter(s + o);
            end
            io.start   = (o == 0 || holdStart) ? 1'b1 : 1'($urandom);
            io.num_vec = (o == 0) ? CNT_W'(nv) : CNT_W'($urandom);
            if (o >= 1 && o <= lastW) begin
                io.w_valid = wvA[o]; io.w_data = wdA[o];
            end else begin
                io.w_valid = 1'($urandom); io.w_data = WIDTH'($urandom);
            end
            if (nvEff > 0 && o >= streamStart && o <= lastF) begin
                io.f_valid = fvA[o]; io.f_data = fdA[o];
            end else begin
                io.f_valid = 1'($urandom); io.f_data = FW'({$urandom, $urandom});
            end
            @(posedge clk);
            #1;
            if (o == abortOff) begin
                rst = 1'b0;
                break;
            end
        end
        if (!holdStart) io.start = 1'b0;
    endtask

    // Monitor: level outputs every cycle, weight and done events popped from their scoreboards
    initial begin
        wEvent_t we;
        dEvent_t de;
        forever begin
            @(negedge clk);
            if (checkEn) begin
                checkOutput("busy", 64'(io.busy), 64'(expBusy.exists(cyc)));
                checkOutput("w_ready", 64'(io.w_ready), 64'(expWReady.exists(cyc)));
                checkOutput("f_ready", 64'(io.f_ready), 64'(expFReady.exists(cyc)));
                checkOutput("pe_feature", 64'(io.pe_feature), expFeat.exists(cyc) ? 64'(expFeat[cyc]) : 64'd0);
                if (io.pe_ctrl === 1'b1) begin
                    if (weightQ.size() == 0) begin
                        checkOutput("pe_ctrl", 64'(io.pe_ctrl), 64'd0);
                    end else begin
                        we = weightQ.pop_front();
                        checkOutput("pe_ctrl_cycle", 64'(cyc), 64'(we.cyc));
                        checkOutput("pe_weight", 64'(io.pe_weight), 64'(we.val));
                    end
                end else if (weightQ.size() > 0 && weightQ[0].cyc <= cyc) begin
                    we = weightQ.pop_front();
                    checkOutput("pe_ctrl", 64'(io.pe_ctrl), 64'd1);
                end
                if (io.done === 1'b1) begin
                    if (doneQ.size() == 0) begin
                        checkOutput("done", 64'(io.done), 64'd0);
                    end else begin
                        de = doneQ.pop_front();
                        checkOutput("done_cycle", 64'(cyc), 64'(de.cyc));
`ifdef STALL_CNT_EN
                        checkOutput("stall_cnt", 64'(io.stall_cnt), 64'(de.stalls));
`endif
                    end
                end else if (doneQ.size() > 0 && doneQ[0].cyc <= cyc) begin
                    de = doneQ.pop_front();
                    checkOutput("done", 64'(io.done), 64'd1);
                end
            end
        end
    end

    // Scenario sequence
    initial begin
        io.start = 1'b0; io.num_vec = '0; io.w_valid = 1'b0; io.w_data = '0;
        io.f_valid = 1'b0; io.f_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("reset_pe_weight", 64'(io.pe_weight), 64'd0);
        checkOutput("reset_pe_ctrl", 64'(io.pe_ctrl), 64'd0);
        checkOutput("reset_done", 64'(io.done), 64'd0);

        // Directed job: weights 5,6,7 and features {1,2,3},{4,5,6}, no stalls
        wGap = '{0, 0, 0}; wData = '{8'd5, 8'd6, 8'd7};
        fGap.delete(); fData.delete();
        fGap.push_back(0); fData.push_back(24'h030201);
        fGap.push_back(0); fData.push_back(24'h060504);
        applyStimulus(2, 1'b0, -1);
        idle(3);

        // Same job with a two-cycle weight stall and a one-cycle feature stall
        wGap = '{0, 2, 0};
        fGap.delete(); fGap.push_back(0); fGap.push_back(1);
        applyStimulus(2, 1'b0, -1);
        idle(3);

        // Empty job: weights only, then drain
        planRandom(0, 0);
        applyStimulus(0, 1'b0, -1);
        idle(2);

        // start held high through a job; re-accepted immediately after done
        planRandom(2, 0);
        applyStimulus(2, 1'b1, -1);
        planRandom(3, 1);
        applyStimulus(3, 1'b0, -1);
        idle(3);

        // Reset in STREAM with data in the skew, then a clean job
        planRandom(4, 0);
        applyStimulus(4, 1'b0, 6);
        @(negedge clk);
        checkOutput("abort_pe_weight", 64'(io.pe_weight), 64'd0);
        checkOutput("abort_pe_feature", 64'(io.pe_feature), 64'd0);
        checkOutput("abort_busy", 64'(io.busy), 64'd0);
        idle(2);
        wGap = '{0, 0, 0}; wData = '{8'd5, 8'd6, 8'd7};
        fGap.delete(); fData.delete();
        fGap.push_back(0); fData.push_back(24'h030201);
        fGap.push_back(0); fData.push_back(24'h060504);
        applyStimulus(2, 1'b0, -1);
        idle(2);

        // Oversized job is clamped to MAX_VEC
        planRandom(MAX_VEC + 5, 0);
        applyStimulus(MAX_VEC + 5, 1'b0, -1);
        idle(2);

        // Randomized jobs with stalls and random idle gaps
        for (int n = 0; n < 10; n++) begin
            int nv;
            nv = $urandom_range(0, 10);
            planRandom(nv, 3);
            applyStimulus(nv, 1'b0, -1);
            idle($urandom_range(0, 3));
        end

        idle(5);
        checkOutput("weight_events_left", 64'(weightQ.size()), 64'd0);
        checkOutput("done_events_left", 64'(doneQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
